// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between the DMA TX engine (master) and the UART serializer (slave).
// A byte moves on a rising clock edge where TX_Valid and TX_Ready are both high.
interface uart_tx_serializer_if;
    logic       TX_Valid;
    logic [7:0] TX_Data;
    logic       TX_Ready;

    modport master (output TX_Valid, output TX_Data, input TX_Ready);
    modport slave  (input TX_Valid, input TX_Data, output TX_Ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmitter producing 8N1 frames: start bit, 8 data bits LSB first, stop bit.
// A one-byte holding register accepts the next byte while the current frame shifts out,
// so consecutive bytes go on the line with no idle gap between them.
// Optional build macro UART_TX_PARITY_EN inserts a parity bit between the data and stop
// bits, with sense set by PARITY_ODD (0 = even, 1 = odd).
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    uart_tx_serializer_if.slave  tx,
    output logic                 TXD,
    output logic                 Busy
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    logic             r_hold_v;
    logic [7:0]       r_hold_data;
    logic [7:0]       r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic             r_txd;

    state_t           w_state_nxt;
    logic             w_hold_v_nxt;
    logic [7:0]       w_hold_data_nxt;
    logic [7:0]       w_shift_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_idx_nxt;
    logic             w_txd_nxt;
    logic             w_bit_end;
    logic             w_accept;
    logic             w_load;

`ifdef UART_TX_PARITY_EN
    logic             r_parity;
    logic             w_parity_nxt;

    // Parity of a byte, optionally inverted for odd sense.
    function automatic logic parity8(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction
`endif

    assign tx.TX_Ready = !r_hold_v;
    assign TXD         = r_txd;
    assign Busy        = (r_state != S_IDLE) || r_hold_v;

    assign w_bit_end = (r_cnt == CNT_LAST);
    assign w_accept  = tx.TX_Valid && !r_hold_v;

    // Next-state, baud timing, shift and holding-register control.
    always_comb begin
        w_state_nxt     = r_state;
        w_hold_v_nxt    = r_hold_v;
        w_hold_data_nxt = r_hold_data;
        w_shift_nxt     = r_shift;
        w_cnt_nxt       = {CNT_W{1'b0}};
        w_bit_idx_nxt   = r_bit_idx;
        w_txd_nxt       = r_txd;
        w_load          = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt    = r_parity;
`endif

        if (r_state != S_IDLE) begin
            w_cnt_nxt = w_bit_end ? {CNT_W{1'b0}} : r_cnt + CNT_W'(1);
        end else begin
            w_cnt_nxt = {CNT_W{1'b0}};
        end

        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                if (r_hold_v) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                    w_txd_nxt   = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = S_DATA;
                    w_bit_idx_nxt = 3'd0;
                    w_txd_nxt     = r_shift[0];
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_txd_nxt   = r_parity;
`else
                        w_state_nxt = S_STOP;
                        w_txd_nxt   = 1'b1;
`endif
                    end else begin
                        // The bit now going out is the one that becomes shift[0].
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_txd_nxt     = r_shift[1];
                    end
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_txd_nxt   = 1'b1;
                end else begin
                    w_state_nxt = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_hold_v) begin
                        // Chain straight into the next frame: no idle cycle on the line.
                        w_load      = 1'b1;
                        w_state_nxt = S_START;
                        w_txd_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_txd_nxt   = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_STOP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_txd_nxt   = 1'b1;
            end
        endcase

        // Load only happens with hold_v=1, when TX_Ready is 0, so it never meets an accept.
        if (w_load) begin
            w_shift_nxt   = r_hold_data;
            w_hold_v_nxt  = 1'b0;
            w_bit_idx_nxt = 3'd0;
`ifdef UART_TX_PARITY_EN
            w_parity_nxt  = parity8(r_hold_data, PARITY_ODD);
`endif
        end else if (w_accept) begin
            w_hold_v_nxt    = 1'b1;
            w_hold_data_nxt = tx.TX_Data;
        end else begin
            w_hold_v_nxt = r_hold_v;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state     <= S_IDLE;
            r_hold_v    <= 1'b0;
            r_hold_data <= 8'h00;
            r_shift     <= 8'h00;
            r_cnt       <= {CNT_W{1'b0}};
            r_bit_idx   <= 3'd0;
            r_txd       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_hold_v    <= w_hold_v_nxt;
            r_hold_data <= w_hold_data_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_txd       <= w_txd_nxt;
`ifdef UART_TX_PARITY_EN
            r_parity    <= w_parity_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: table of single frames plus hand-written
// back-to-back, backpressure, mid-frame reset and minimum-bit-period sequences.
module tb_uart_tx_serializer;

    localparam int CPB_A = 4;
    localparam int CPB_B = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL_A = NBITS * CPB_A;
    localparam int FL_B = NBITS * CPB_B;

    logic Clk = 1'b0;
    logic Rst_n;
    logic txd_a, busy_a, txd_b, busy_b;

    always #5 Clk = ~Clk;

    uart_tx_serializer_if if_a ();
    uart_tx_serializer_if if_b ();

    uart_tx_serializer #(.CLKS_PER_BIT(CPB_A), .PARITY_ODD(1'b0)) u_dut_a (
        .Clk(Clk), .Rst_n(Rst_n), .tx(if_a), .TXD(txd_a), .Busy(busy_a));

    uart_tx_serializer #(.CLKS_PER_BIT(CPB_B), .PARITY_ODD(1'b1)) u_dut_b (
        .Clk(Clk), .Rst_n(Rst_n), .tx(if_b), .TXD(txd_b), .Busy(busy_b));

    // line: bit 9 = start, bits 8..1 = data in time order (LSB first), bit 0 = stop
    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
        logic       par;   // even parity of data
    } vec_t;

    vec_t vecs [6];
    int   n_pass  = 0;
    int   n_total = 0;
    logic exp_q [$];
    logic rdy_hist [0:255];

    task automatic check1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Expected per-cycle line levels for one frame.
    task automatic push_frame(input logic [9:0] line, input logic par, input logic podd, input int cpb);
        for (int k = 9; k >= 0; k--) begin
`ifdef UART_TX_PARITY_EN
            if (k == 0) repeat (cpb) exp_q.push_back(par ^ podd);
`endif
            repeat (cpb) exp_q.push_back(line[k]);
        end
    endtask

    // Present a byte on DUT A and return just after the accepting edge; TX_Valid stays high.
    task automatic drive_a(input logic [7:0] d);
        int t;
        t = 0;
        @(negedge Clk);
        if_a.TX_Valid = 1'b1;
        if_a.TX_Data  = d;
        while (!if_a.TX_Ready && t < 400) begin
            @(negedge Clk);
            t++;
        end
        if (t >= 400) fail_now("accept_timeout");
        @(posedge Clk);
    endtask

    // Wait for the start bit, then compare every cycle of the expected stream.
    task automatic sample_a(input string tag);
        int t;
        t = 0;
        @(negedge Clk);
        while (txd_a !== 1'b0 && t < 200) begin
            @(negedge Clk);
            t++;
        end
        if (t >= 200) fail_now({tag, "_start_timeout"});
        for (int i = 0; i < exp_q.size(); i++) begin
            check1($sformatf("%s_txd%0d", tag, i), txd_a, exp_q[i]);
            rdy_hist[i] = if_a.TX_Ready;
            @(negedge Clk);
        end
        rdy_hist[exp_q.size()] = if_a.TX_Ready;
        check1({tag, "_end_busy"}, busy_a, 1'b0);
        check1({tag, "_end_txd"}, txd_a, 1'b1);
    endtask

    // One byte from idle with exact latency and Busy-duration checks.
    task automatic single_a(input logic [7:0] d, input logic [9:0] line, input logic par, input string tag);
        int busy_cnt;
        exp_q.delete();
        push_frame(line, par, 1'b0, CPB_A);
        drive_a(d);
        @(negedge Clk);
        if_a.TX_Valid = 1'b0;
        busy_cnt = busy_a ? 1 : 0;
        check1({tag, "_txd_at_accept"}, txd_a, 1'b1);
        check1({tag, "_ready_held"}, if_a.TX_Ready, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge Clk);
            check1($sformatf("%s_txd%0d", tag, i), txd_a, exp_q[i]);
            if (busy_a) busy_cnt++;
        end
        @(negedge Clk);
        check1({tag, "_busy_end"}, busy_a, 1'b0);
        check1({tag, "_ready_end"}, if_a.TX_Ready, 1'b1);
        check1({tag, "_txd_end"}, txd_a, 1'b1);
        checkn({tag, "_busy_cycles"}, busy_cnt, exp_q.size() + 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int zeros;
        int busies;
        int early_rdy;

        vecs[0] = '{8'hA5, 10'b0_10100101_1, 1'b0};
        vecs[1] = '{8'h12, 10'b0_01001000_1, 1'b0};
        vecs[2] = '{8'h07, 10'b0_11100000_1, 1'b1};
        vecs[3] = '{8'h80, 10'b0_00000001_1, 1'b1};
        vecs[4] = '{8'h00, 10'b0_00000000_1, 1'b0};
        vecs[5] = '{8'hFF, 10'b0_11111111_1, 1'b0};

        Rst_n         = 1'b0;
        if_a.TX_Valid = 1'b0;
        if_a.TX_Data  = 8'h00;
        if_b.TX_Valid = 1'b0;
        if_b.TX_Data  = 8'h00;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check1("rst_txd_a", txd_a, 1'b1);
        check1("rst_ready_a", if_a.TX_Ready, 1'b1);
        check1("rst_busy_a", busy_a, 1'b0);
        check1("rst_txd_b", txd_b, 1'b1);
        check1("rst_busy_b", busy_b, 1'b0);
        Rst_n = 1'b1;

        // Single frames from the table.
        for (int v = 0; v < 6; v++) begin
            single_a(vecs[v].data, vecs[v].line, vecs[v].par, $sformatf("vec%0d", v));
        end

        // Back-to-back 0x12 then 0x34: second frame starts right after the first stop bit.
        exp_q.delete();
        push_frame(10'b0_01001000_1, 1'b0, 1'b0, CPB_A);
        push_frame(10'b0_00101100_1, 1'b1, 1'b0, CPB_A);
        fork
            begin
                drive_a(8'h12);
                drive_a(8'h34);
                @(negedge Clk);
                if_a.TX_Valid = 1'b0;
            end
            sample_a("b2b");
        join
        early_rdy = 0;
        for (int i = 1; i < FL_A; i++) if (rdy_hist[i]) early_rdy++;
        checkn("b2b_ready_low_during_first", early_rdy, 0);
        check1("b2b_ready_at_second_load", rdy_hist[FL_A], 1'b1);

        // Backpressure: TX_Valid held high across three bytes.
        exp_q.delete();
        push_frame(10'b0_10101010_1, 1'b0, 1'b0, CPB_A);
        push_frame(10'b0_01010101_1, 1'b0, 1'b0, CPB_A);
        push_frame(10'b0_11110000_1, 1'b0, 1'b0, CPB_A);
        fork
            begin
                drive_a(8'h55);
                drive_a(8'hAA);
                drive_a(8'h0F);
                @(negedge Clk);
                if_a.TX_Valid = 1'b0;
            end
            sample_a("bp");
        join
        zeros  = 0;
        busies = 0;
        repeat (2 * FL_A) begin
            @(negedge Clk);
            if (txd_a !== 1'b1) zeros++;
            if (busy_a) busies++;
        end
        checkn("bp_no_extra_frame", zeros, 0);
        checkn("bp_no_busy_after", busies, 0);

        // Reset during data bit 3 of 0xFF.
        drive_a(8'hFF);
        @(negedge Clk);
        if_a.TX_Valid = 1'b0;
        repeat (18) @(negedge Clk);
        check1("rst_mid_bit3_level", txd_a, 1'b1);
        check1("rst_mid_busy_before", busy_a, 1'b1);
        Rst_n = 1'b0;
        @(negedge Clk);
        check1("rst_mid_txd", txd_a, 1'b1);
        check1("rst_mid_ready", if_a.TX_Ready, 1'b1);
        check1("rst_mid_busy", busy_a, 1'b0);
        Rst_n = 1'b1;
        single_a(8'h01, 10'b0_10000000_1, 1'b1, "post_rst");

        // Minimum bit period on DUT B (odd parity sense when parity is built in).
        exp_q.delete();
        push_frame(10'b0_00000001_1, 1'b1, 1'b1, CPB_B);
        @(negedge Clk);
        if_b.TX_Valid = 1'b1;
        if_b.TX_Data  = 8'h80;
        @(posedge Clk);
        @(negedge Clk);
        if_b.TX_Valid = 1'b0;
        check1("min_txd_at_accept", txd_b, 1'b1);
        for (int i = 0; i < FL_B; i++) begin
            @(negedge Clk);
            check1($sformatf("min_txd%0d", i), txd_b, exp_q[i]);
        end
        @(negedge Clk);
        check1("min_busy_end", busy_b, 1'b0);
        check1("min_ready_end", if_b.TX_Ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
